writeback: RTL and testbench

- Final stage of the processor pipeline; drives the register-file write port (wr_en / wr_reg / wr_data) that the decode stage consumes.
- Holds the MEM/WB pipeline register and selects the write-back value from the ALU, memory, link PC, set flag or immediate paths.
- Waits on the multi-cycle data memory for loads, asserting a stall upstream until data is ready.
- Provides a one-cycle bypass of the last committed write, so decode can forward around the register file's write-then-read timing.

---
 rtl/wb_pkg.sv | 19 +
 rtl/writeback_if.sv | 43 ++++
 rtl/wb_result_mux.sv | 32 +++
 rtl/writeback.sv | 142 ++++++++++++++
 tb/tb_writeback.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back result selects, FSM encodings and defaults
package wb_pkg;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_MEM  = 3'd1;
  localparam logic [2:0] WB_PC2  = 3'd2;
  localparam logic [2:0] WB_SET  = 3'd3;
  localparam logic [2:0] WB_LBI  = 3'd4;
  localparam logic [2:0] WB_SLBI = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WB       = 2'd1,
    ST_WAIT_MEM = 2'd2
  } wb_state_e;

  localparam int WB_MEM_TIMEOUT = 15;

endpackage

// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - MEM/WB inputs, memory response, register-file write and bypass
interface writeback_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              in_valid;
  logic              in_wr_en;
  logic [REG_W-1:0]  in_wr_reg;
  logic [2:0]        in_wr_sel;
  logic              in_mem_rd;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc_plus2;
  logic              set_flag;
  logic [DATA_W-1:0] sext_imm;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] mem_data;
  logic              mem_done;
  logic              stall_out;
  logic              out_wr_en;
  logic [REG_W-1:0]  out_wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              byp_valid;
  logic [REG_W-1:0]  byp_reg;
  logic [DATA_W-1:0] byp_data;
  logic              err;

  modport master (
    output in_valid, in_wr_en, in_wr_reg, in_wr_sel, in_mem_rd,
    output alu_result, pc_plus2, set_flag, sext_imm, rs_data,
    output mem_data, mem_done,
    input  stall_out, out_wr_en, out_wr_reg, wr_data,
    input  byp_valid, byp_reg, byp_data, err
  );

  modport slave (
    input  in_valid, in_wr_en, in_wr_reg, in_wr_sel, in_mem_rd,
    input  alu_result, pc_plus2, set_flag, sext_imm, rs_data,
    input  mem_data, mem_done,
    output stall_out, out_wr_en, out_wr_reg, wr_data,
    output byp_valid, byp_reg, byp_data, err
  );

endinterface

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - selects the write-back value and flags reserved selects
module wb_result_mux #(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic              set_flag,
  input  logic [DATA_W-1:0] sext_imm,
  input  logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] result,
  output logic              reserved
);
  import wb_pkg::*;

  // Result select; SLBI shifts Rs up a byte and merges the low immediate byte
  always_comb begin
    result   = '0;
    reserved = 1'b0;
    case (wr_sel)
      WB_ALU:  result = alu_result;
      WB_MEM:  result = mem_data;
      WB_PC2:  result = pc_plus2;
      WB_SET:  result = {{(DATA_W-1){1'b0}}, set_flag};
      WB_LBI:  result = sext_imm;
      WB_SLBI: result = (rs_data << 8) | {{(DATA_W-8){1'b0}}, sext_imm[7:0]};
      default: reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - MEM/WB latch, load wait with timeout, register write and bypass
module writeback import wb_pkg::*; #(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = WB_MEM_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  writeback_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  wb_state_e         state, state_nxt, entry_state;
  logic              lat_valid, lat_wr_en, lat_mem_rd, lat_flag;
  logic [REG_W-1:0]  lat_wr_reg;
  logic [2:0]        lat_wr_sel;
  logic [DATA_W-1:0] lat_alu, lat_pc, lat_imm, lat_rs;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] result;
  logic              reserved, timeout, x_seen, stall, wr_en_c;
  logic              byp_valid_q, err_q;
  logic [REG_W-1:0]  byp_reg_q;
  logic [DATA_W-1:0] byp_data_q;

  wb_result_mux #(.DATA_W(DATA_W)) u_mux (
    .wr_sel     (lat_wr_sel),
    .alu_result (lat_alu),
    .mem_data   (bus.mem_data),
    .pc_plus2   (lat_pc),
    .set_flag   (lat_flag),
    .sext_imm   (lat_imm),
    .rs_data    (lat_rs),
    .result     (result),
    .reserved   (reserved)
  );

  assign entry_state = !bus.in_valid ? ST_IDLE : (bus.in_mem_rd ? ST_WAIT_MEM : ST_WB);
  assign timeout = (state == ST_WAIT_MEM) && !bus.mem_done &&
                   (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign x_seen  = $isunknown(bus.in_valid) ||
                   (bus.in_valid && $isunknown({bus.in_wr_en, bus.in_wr_sel})) ||
                   (lat_valid && lat_mem_rd && $isunknown(bus.mem_done));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: advance whenever the latch is free to take the next instruction
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_WB: state_nxt = entry_state;
      ST_WAIT_MEM: begin
        if (bus.mem_done)  state_nxt = entry_state;
        else if (timeout)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: write in WB, or in WAIT_MEM once memory answers; stall while it has not
  always_comb begin
    stall   = 1'b0;
    wr_en_c = 1'b0;
    case (state)
      ST_WB: wr_en_c = lat_wr_en && !reserved;
      ST_WAIT_MEM: begin
        if (bus.mem_done) wr_en_c = lat_wr_en && !reserved;
        else              stall   = 1'b1;
      end
      default: ;
    endcase
  end

  // MEM/WB latch; a timed-out load is dropped so the held instruction can follow
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_valid  <= 1'b0;
      lat_wr_en  <= 1'b0;
      lat_wr_reg <= '0;
      lat_wr_sel <= '0;
      lat_mem_rd <= 1'b0;
      lat_alu    <= '0;
      lat_pc     <= '0;
      lat_flag   <= 1'b0;
      lat_imm    <= '0;
      lat_rs     <= '0;
    end else if (!stall) begin
      lat_valid  <= bus.in_valid;
      lat_wr_en  <= bus.in_wr_en;
      lat_wr_reg <= bus.in_wr_reg;
      lat_wr_sel <= bus.in_wr_sel;
      lat_mem_rd <= bus.in_mem_rd;
      lat_alu    <= bus.alu_result;
      lat_pc     <= bus.pc_plus2;
      lat_flag   <= bus.set_flag;
      lat_imm    <= bus.sext_imm;
      lat_rs     <= bus.rs_data;
    end else if (timeout) begin
      lat_valid  <= 1'b0;
    end
  end

  // Memory wait counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (stall && !timeout) wait_cnt <= wait_cnt + CNT_W'(1);
      else                   wait_cnt <= '0;
      if (timeout || x_seen || (lat_valid && lat_wr_en && reserved)) err_q <= 1'b1;
    end
  end

  // One-cycle bypass of the write committed at this edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      byp_valid_q <= 1'b0;
      byp_reg_q   <= '0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= wr_en_c;
      if (wr_en_c) begin
        byp_reg_q  <= lat_wr_reg;
        byp_data_q <= result;
      end
    end
  end

  assign bus.stall_out  = stall;
  assign bus.out_wr_en  = wr_en_c;
  assign bus.out_wr_reg = lat_wr_reg;
  assign bus.wr_data    = result;
  assign bus.byp_valid  = byp_valid_q;
  assign bus.byp_reg    = byp_reg_q;
  assign bus.byp_data   = byp_data_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - directed and randomized bench for writeback
module tb_writeback;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_if #(.DATA_W(16), .REG_W(3)) bus ();

  writeback #(.DATA_W(16), .REG_W(3), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        valid;
    logic        wr_en;
    logic [2:0]  dst;
    logic [2:0]  sel;
    logic        mem_rd;
    logic [15:0] alu;
    logic [15:0] pc;
    logic        flag;
    logic [15:0] imm;
    logic [15:0] rs;
  } ins_t;

  wire [19:0] wr_port  = {bus.out_wr_en, bus.out_wr_reg, bus.wr_data};
  wire [19:0] byp_port = {bus.byp_valid, bus.byp_reg, bus.byp_data};

  function automatic ins_t mk(input logic wr_en, input logic [2:0] dst,
                              input logic [2:0] sel, input logic mem_rd);
    ins_t i;
    i = '0;
    i.valid = 1'b1; i.wr_en = wr_en; i.dst = dst; i.sel = sel; i.mem_rd = mem_rd;
    return i;
  endfunction

  function automatic logic [15:0] ref_result(input ins_t i, input logic [15:0] md);
    case (i.sel)
      3'd0: return i.alu;
      3'd1: return md;
      3'd2: return i.pc;
      3'd3: return {15'b0, i.flag};
      3'd4: return i.imm;
      3'd5: return {i.rs[7:0], i.imm[7:0]};
      default: return 16'h0;
    endcase
  endfunction

  task automatic apply(input ins_t i);
    bus.in_valid   = i.valid;
    bus.in_wr_en   = i.wr_en;
    bus.in_wr_reg  = i.dst;
    bus.in_wr_sel  = i.sel;
    bus.in_mem_rd  = i.mem_rd;
    bus.alu_result = i.alu;
    bus.pc_plus2   = i.pc;
    bus.set_flag   = i.flag;
    bus.sext_imm   = i.imm;
    bus.rs_data    = i.rs;
  endtask

  task automatic idle_in();
    ins_t i;
    i = '0;
    apply(i);
  endtask

  task automatic test_reset();
    ins_t i;
    i = mk(1'b1, 3'd3, 3'd0, 1'b0); i.alu = 16'h1234;
    rst = 1'b0; apply(i); bus.mem_done = 1'b1; bus.mem_data = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if ({bus.stall_out, bus.err} !== 2'b00) begin n_err++; $display("FAIL reset_stall_err got=%b want=00", {bus.stall_out, bus.err}); end
    n_vec++; if (wr_port !== 20'h0) begin n_err++; $display("FAIL reset_wr got=%h want=00000", wr_port); end
    n_vec++; if (byp_port !== 20'h0) begin n_err++; $display("FAIL reset_byp got=%h want=00000", byp_port); end
    idle_in(); bus.mem_done = 1'b0; rst = 1'b1;
  endtask

  task automatic test_alu();
    ins_t i;
    logic [19:0] e;
    @(negedge clk); i = mk(1'b1, 3'd3, 3'd0, 1'b0); i.alu = 16'h1234; apply(i);
    @(negedge clk); idle_in(); #1;
    n_vec++; if (bus.stall_out !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%b want=0", bus.stall_out); end
    e = {1'b1, 3'd3, 16'h1234};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL alu_write got=%h want=%h", wr_port, e); end
    @(negedge clk); #1;
    n_vec++; if (byp_port !== e) begin n_err++; $display("FAIL alu_byp got=%h want=%h", byp_port, e); end
    n_vec++; if (bus.out_wr_en !== 1'b0) begin n_err++; $display("FAIL alu_single got=%b want=0", bus.out_wr_en); end
    @(negedge clk); #1;
    n_vec++; if (bus.byp_valid !== 1'b0) begin n_err++; $display("FAIL alu_byp_drop got=%b want=0", bus.byp_valid); end
  endtask

  task automatic test_load();
    ins_t ld, nx;
    int stalls;
    logic [19:0] e;
    stalls = 0;
    ld = mk(1'b1, 3'd5, 3'd1, 1'b1);
    nx = mk(1'b1, 3'd2, 3'd0, 1'b0); nx.alu = 16'h5555;
    @(negedge clk); apply(ld); bus.mem_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); if (k == 0) apply(nx); #1;
      if (bus.stall_out === 1'b1 && bus.out_wr_en === 1'b0) stalls++;
    end
    n_vec++; if (stalls != 3) begin n_err++; $display("FAIL load_stalls got=%0d want=3", stalls); end
    @(negedge clk); bus.mem_data = 16'hBEEF; bus.mem_done = 1'b1; #1;
    n_vec++; if (bus.stall_out !== 1'b0) begin n_err++; $display("FAIL load_release got=%b want=0", bus.stall_out); end
    e = {1'b1, 3'd5, 16'hBEEF};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL load_write got=%h want=%h", wr_port, e); end
    @(negedge clk); bus.mem_done = 1'b0; bus.mem_data = 16'h0; idle_in(); #1;
    n_vec++; if (byp_port !== e) begin n_err++; $display("FAIL load_byp got=%h want=%h", byp_port, e); end
    e = {1'b1, 3'd2, 16'h5555};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL load_follow got=%h want=%h", wr_port, e); end
    @(negedge clk); #1;
    n_vec++; if (bus.out_wr_en !== 1'b0) begin n_err++; $display("FAIL load_single got=%b want=0", bus.out_wr_en); end
  endtask

  task automatic test_slbi_jal();
    ins_t i;
    logic [19:0] e;
    @(negedge clk); i = mk(1'b1, 3'd4, 3'd5, 1'b0); i.rs = 16'h00AB; i.imm = 16'hFFCD; apply(i);
    @(negedge clk); i = mk(1'b1, 3'd7, 3'd2, 1'b0); i.pc = 16'h0042; apply(i); #1;
    e = {1'b1, 3'd4, 16'hABCD};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL slbi got=%h want=%h", wr_port, e); end
    @(negedge clk); i = mk(1'b1, 3'd6, 3'd3, 1'b0); i.flag = 1'b1; apply(i); #1;
    e = {1'b1, 3'd7, 16'h0042};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL jal got=%h want=%h", wr_port, e); end
    @(negedge clk); i = mk(1'b1, 3'd0, 3'd4, 1'b0); i.imm = 16'hFF80; apply(i); #1;
    e = {1'b1, 3'd6, 16'h0001};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL set got=%h want=%h", wr_port, e); end
    @(negedge clk); idle_in(); #1;
    e = {1'b1, 3'd0, 16'hFF80};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL lbi got=%h want=%h", wr_port, e); end
    @(negedge clk); #1;
    n_vec++; if (byp_port !== e) begin n_err++; $display("FAIL lbi_byp got=%h want=%h", byp_port, e); end
  endtask

  task automatic test_back_to_back();
    ins_t i;
    logic [19:0] e1, e2;
    e1 = {1'b1, 3'd1, 16'hA1A1};
    e2 = {1'b1, 3'd2, 16'hB2B2};
    @(negedge clk); i = mk(1'b1, 3'd1, 3'd0, 1'b0); i.alu = 16'hA1A1; apply(i);
    @(negedge clk); i = mk(1'b1, 3'd2, 3'd0, 1'b0); i.alu = 16'hB2B2; apply(i); #1;
    n_vec++; if (wr_port !== e1) begin n_err++; $display("FAIL b2b_w1 got=%h want=%h", wr_port, e1); end
    @(negedge clk); idle_in(); #1;
    n_vec++; if (wr_port !== e2) begin n_err++; $display("FAIL b2b_w2 got=%h want=%h", wr_port, e2); end
    n_vec++; if (byp_port !== e1) begin n_err++; $display("FAIL b2b_byp1 got=%h want=%h", byp_port, e1); end
    @(negedge clk); #1;
    n_vec++; if (byp_port !== e2) begin n_err++; $display("FAIL b2b_byp2 got=%h want=%h", byp_port, e2); end
    @(negedge clk); #1;
    n_vec++; if (bus.byp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_byp_drop got=%b want=0", bus.byp_valid); end
  endtask

  task automatic test_no_write();
    ins_t i;
    @(negedge clk); i = mk(1'b0, 3'd3, 3'd0, 1'b0); i.alu = 16'h7777; apply(i);
    @(negedge clk); i = mk(1'b0, 3'd4, 3'd1, 1'b1); apply(i); bus.mem_done = 1'b1; #1;
    n_vec++; if ({bus.out_wr_en, bus.stall_out} !== 2'b00) begin n_err++; $display("FAIL store_nowrite got=%b want=00", {bus.out_wr_en, bus.stall_out}); end
    @(negedge clk); idle_in(); bus.mem_done = 1'b1; #1;
    n_vec++; if ({bus.out_wr_en, bus.stall_out} !== 2'b00) begin n_err++; $display("FAIL ld_noen got=%b want=00", {bus.out_wr_en, bus.stall_out}); end
    @(negedge clk); bus.mem_done = 1'b0; #1;
    n_vec++; if (bus.byp_valid !== 1'b0) begin n_err++; $display("FAIL noen_byp got=%b want=0", bus.byp_valid); end
  endtask

  // One-entry pipeline model: the held instruction writes when it is not a load or
  // when memory answers; upstream repeats its instruction while a load is waiting.
  task automatic test_random();
    ins_t drv, cur;
    logic have, hold, md, exp_we, exp_st, bv;
    logic [15:0] mdata, bd;
    logic [2:0] br;
    int lowrun;
    have = 1'b0; hold = 1'b0; bv = 1'b0; br = '0; bd = '0; lowrun = 0;
    drv = '0; cur = '0;
    repeat (2) begin @(negedge clk); idle_in(); bus.mem_done = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!hold) begin
        drv.valid  = ($urandom_range(0, 9) < 8);
        drv.wr_en  = ($urandom_range(0, 9) < 8);
        drv.dst    = 3'($urandom_range(0, 7));
        drv.sel    = 3'($urandom_range(0, 5));
        drv.mem_rd = ($urandom_range(0, 9) < 3);
        drv.alu    = 16'($urandom);
        drv.pc     = 16'($urandom);
        drv.flag   = 1'($urandom);
        drv.imm    = 16'($urandom);
        drv.rs     = 16'($urandom);
      end
      apply(drv);
      md = (lowrun >= 8) ? 1'b1 : ($urandom_range(0, 9) < 4);
      lowrun = md ? 0 : lowrun + 1;
      mdata = 16'($urandom);
      bus.mem_done = md; bus.mem_data = mdata;
      #1;
      exp_we = have && cur.wr_en && (!cur.mem_rd || md);
      exp_st = have && cur.mem_rd && !md;
      n_vec++; if (bus.stall_out !== exp_st) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", c, bus.stall_out, exp_st); end
      n_vec++; if (bus.out_wr_en !== exp_we) begin n_err++; $display("FAIL rnd_wr_en cyc=%0d got=%b want=%b", c, bus.out_wr_en, exp_we); end
      if (exp_we) begin
        n_vec++;
        if ({bus.out_wr_reg, bus.wr_data} !== {cur.dst, ref_result(cur, mdata)}) begin
          n_err++; $display("FAIL rnd_wr_data cyc=%0d got=%h want=%h", c, {bus.out_wr_reg, bus.wr_data}, {cur.dst, ref_result(cur, mdata)});
        end
      end
      n_vec++; if (bus.byp_valid !== bv) begin n_err++; $display("FAIL rnd_byp_valid cyc=%0d got=%b want=%b", c, bus.byp_valid, bv); end
      if (bv) begin
        n_vec++; if ({bus.byp_reg, bus.byp_data} !== {br, bd}) begin n_err++; $display("FAIL rnd_byp cyc=%0d got=%h want=%h", c, {bus.byp_reg, bus.byp_data}, {br, bd}); end
      end
      bv = exp_we;
      if (exp_we) begin br = cur.dst; bd = ref_result(cur, mdata); end
      if (!exp_st) begin have = drv.valid; cur = drv; end
      hold = exp_st;
    end
    @(negedge clk); idle_in(); bus.mem_done = 1'b1;
    @(negedge clk); bus.mem_done = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rnd_err got=%b want=0", bus.err); end
  endtask

  task automatic test_reset_wait();
    ins_t i;
    @(negedge clk); i = mk(1'b1, 3'd3, 3'd1, 1'b1); apply(i); bus.mem_done = 1'b0;
    @(negedge clk); idle_in(); #1;
    n_vec++; if (bus.stall_out !== 1'b1) begin n_err++; $display("FAIL rstw_stall got=%b want=1", bus.stall_out); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; bus.mem_done = 1'b1; bus.mem_data = 16'hDEAD; #1;
    n_vec++; if ({bus.out_wr_en, bus.stall_out} !== 2'b00) begin n_err++; $display("FAIL rstw_drop got=%b want=00", {bus.out_wr_en, bus.stall_out}); end
    @(negedge clk); bus.mem_done = 1'b0; #1;
    n_vec++; if (bus.byp_valid !== 1'b0) begin n_err++; $display("FAIL rstw_byp got=%b want=0", bus.byp_valid); end
  endtask

  task automatic test_timeout();
    ins_t ld, nx;
    int stalls, wrs;
    logic [19:0] e;
    stalls = 0; wrs = 0;
    ld = mk(1'b1, 3'd6, 3'd1, 1'b1);
    nx = mk(1'b1, 3'd1, 3'd0, 1'b0); nx.alu = 16'h0F0F;
    @(negedge clk); apply(ld); bus.mem_done = 1'b0; bus.mem_data = 16'h1111;
    @(negedge clk); apply(nx);
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.out_wr_en === 1'b1) wrs++;
      if (bus.stall_out !== 1'b1) break;
      stalls++;
      @(negedge clk);
    end
    n_vec++; if (stalls != 15) begin n_err++; $display("FAIL to_stalls got=%0d want=15", stalls); end
    n_vec++; if (wrs != 0) begin n_err++; $display("FAIL to_nowrite got=%0d want=0", wrs); end
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL to_err got=%b want=1", bus.err); end
    @(negedge clk); idle_in(); #1;
    e = {1'b1, 3'd1, 16'h0F0F};
    n_vec++; if (wr_port !== e) begin n_err++; $display("FAIL to_follow got=%h want=%h", wr_port, e); end
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b want=1", bus.err); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL to_clear got=%b want=0", bus.err); end
  endtask

  task automatic test_reserved();
    ins_t i;
    @(negedge clk); i = mk(1'b1, 3'd2, 3'd6, 1'b0); i.alu = 16'h3333; apply(i);
    @(negedge clk); idle_in(); #1;
    n_vec++; if (bus.out_wr_en !== 1'b0) begin n_err++; $display("FAIL rsv_nowrite got=%b want=0", bus.out_wr_en); end
    @(negedge clk); #1;
    n_vec++; if ({bus.err, bus.byp_valid} !== 2'b10) begin n_err++; $display("FAIL rsv_err got=%b want=10", {bus.err, bus.byp_valid}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_in();
    bus.mem_done = 1'b0;
    bus.mem_data = 16'h0;
    test_reset();
    test_alu();
    test_load();
    test_slbi_jal();
    test_back_to_back();
    test_no_write();
    test_random();
    test_reset_wait();
    test_timeout();
    test_reserved();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
